sseg_scan_monitor: RTL and testbench

- Receive-side counterpart of the 4-digit time-multiplexed 7-segment driver; snoops the active-low `an`/`sseg` scan lines.
- Decodes each digit's segment pattern back to a hex nibble plus decimal-point bit.
- Assembles complete 4-digit frames and publishes them with a one-cycle valid pulse.
- Used as an on-chip self-check of the display path and as a bench monitor for display-driving designs.

---
 rtl/sseg_scan_monitor.sv | 197 +++++++++++++++++++
 tb/tb_sseg_scan_monitor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_monitor.sv
// sseg_scan_monitor: snoops an active-low 4-digit multiplexed 7-segment scan
// (an/sseg), decodes each settled digit back to a hex nibble plus dp level,
// assembles complete frames and publishes them with a one-cycle valid pulse.
// Optional feature macro: SSEG_SCAN_ORDER_CHECK_EN (scan-order checking on scan_err).
module sseg_scan_monitor #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 262144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [15:0] hex,
  output logic [3:0]  dp,
  output logic [3:0]  seg_err,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        stall,
  output logic        scan_err
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE_CYC - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC);

  // Active-low glyph to {err, nibble}; unknown patterns give nibble 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
      7'b0001000: r = 5'h0A;
      7'b0000011: r = 5'h0B;
      7'b1000110: r = 5'h0C;
      7'b0100001: r = 5'h0D;
      7'b0000110: r = 5'h0E;
      7'b0001110: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  logic [3:0]    an_r, an_p;
  logic [7:0]    sseg_r, sseg_p;
  logic [CW-1:0] cnt_r, cnt_nxt;
  logic          captured_r, captured_nxt;
  logic [IW-1:0] idle_r, idle_nxt;
  logic [15:0]   hex_sh;
  logic [3:0]    dp_sh, err_sh;
  logic [3:0]    seen_r, seen_nxt;
  logic          first_r;
  logic          legal_s, same_s, capture_s, seen_full_s;
  logic [1:0]    slot_s;
  logic [4:0]    dec_s;

  // Input stage plus one-cycle history used for the stability comparison.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_r   <= 4'hF;
      sseg_r <= 8'hFF;
      an_p   <= 4'hF;
      sseg_p <= 8'hFF;
    end else begin
      an_r   <= an;
      sseg_r <= sseg;
      an_p   <= an_r;
      sseg_p <= sseg_r;
    end
  end

  // Legality, stability counting, capture decision, idle counting and seen update.
  always_comb begin
    legal_s      = 1'b0;
    slot_s       = 2'd0;
    cnt_nxt      = '0;
    captured_nxt = 1'b0;
    idle_nxt     = idle_r;
    seen_nxt     = seen_r;
    case (an_r)
      4'b1110: begin legal_s = 1'b1; slot_s = 2'd0; end
      4'b1101: begin legal_s = 1'b1; slot_s = 2'd1; end
      4'b1011: begin legal_s = 1'b1; slot_s = 2'd2; end
      4'b0111: begin legal_s = 1'b1; slot_s = 2'd3; end
      default: begin legal_s = 1'b0; slot_s = 2'd0; end
    endcase
    same_s = ({an_r, sseg_r} == {an_p, sseg_p});
    if (!legal_s || !same_s) begin
      cnt_nxt = '0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_nxt = cnt_r;
    end else begin
      cnt_nxt = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
    // The captured flag survives only while the sample stays identical.
    capture_s = legal_s && (cnt_nxt == CNT_MAX) && !(same_s && captured_r);
    if (capture_s) begin
      captured_nxt = 1'b1;
    end else if (legal_s && same_s) begin
      captured_nxt = captured_r;
    end else begin
      captured_nxt = 1'b0;
    end
    if (capture_s) begin
      idle_nxt = '0;
    end else if (idle_r == IDLE_MAX) begin
      idle_nxt = idle_r;
    end else begin
      idle_nxt = idle_r + {{(IW-1){1'b0}}, 1'b1};
    end
    seen_full_s = (seen_r == 4'hF);
    if (seen_full_s) begin
      seen_nxt = 4'h0;
    end else begin
      seen_nxt = seen_r;
    end
    if (capture_s) begin
      seen_nxt[slot_s] = 1'b1;
    end else begin
      seen_nxt = seen_nxt;
    end
    dec_s = decode(sseg_r[6:0]);
  end

  // Counters, shadow frame and publish registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r         <= '0;
      captured_r    <= 1'b0;
      idle_r        <= '0;
      stall         <= 1'b0;
      seen_r        <= 4'h0;
      hex_sh        <= 16'h0000;
      dp_sh         <= 4'h0;
      err_sh        <= 4'h0;
      first_r       <= 1'b1;
      hex           <= 16'h0000;
      dp            <= 4'h0;
      seg_err       <= 4'h0;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt;
      captured_r <= captured_nxt;
      idle_r     <= idle_nxt;
      stall      <= (idle_nxt == IDLE_MAX);
      seen_r     <= seen_nxt;
      if (capture_s) begin
        hex_sh[{slot_s, 2'b00} +: 4] <= dec_s[3:0];
        dp_sh[slot_s]                <= sseg_r[7];
        err_sh[slot_s]               <= dec_s[4];
      end
      if (seen_full_s) begin
        hex           <= hex_sh;
        dp            <= dp_sh;
        seg_err       <= err_sh;
        frame_valid   <= 1'b1;
        frame_changed <= first_r || ({hex_sh, dp_sh, err_sh} != {hex, dp, seg_err});
        first_r       <= 1'b0;
      end else begin
        frame_valid   <= 1'b0;
        frame_changed <= 1'b0;
      end
    end
  end

`ifdef SSEG_SCAN_ORDER_CHECK_EN
  logic [1:0] last_r;
  logic       have_last_r;

  // Flags any capture that does not follow the previous slot in ascending order.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r      <= 2'd0;
      have_last_r <= 1'b0;
      scan_err    <= 1'b0;
    end else begin
      scan_err <= capture_s && have_last_r && (slot_s != (last_r + 2'd1));
      if (capture_s) begin
        last_r      <= slot_s;
        have_last_r <= 1'b1;
      end
    end
  end
`else
  assign scan_err = 1'b0;
`endif

endmodule

// File: tb/tb_sseg_scan_monitor.sv
// Scoreboard bench for sseg_scan_monitor: directed scans from the test plan
// followed by randomized dwells, checked against a frame-level reference model.
module tb_sseg_scan_monitor;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 32;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  err;
    logic        chg;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  an = 4'hF;
  logic [7:0]  sseg = 8'hFF;
  logic [15:0] hex;
  logic [3:0]  dp, seg_err;
  logic        frame_valid, frame_changed, stall, scan_err;

  int n_checks = 0;
  int n_pass   = 0;
  int obs_scan = 0;
  int exp_scan = 0;
  int frames_exp = 0;
  int frames_obs = 0;

  frame_t expq[$];

  // reference model state: one entry per digit slot
  logic [3:0] m_val  [4];
  logic       m_dp   [4];
  logic       m_err  [4];
  logic       m_seen [4];
  logic       m_first;
  frame_t     m_last;
  int         m_last_slot;
  logic       m_have_last;

  sseg_scan_monitor #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .an(an), .sseg(sseg), .hex(hex), .dp(dp),
    .seg_err(seg_err), .frame_valid(frame_valid), .frame_changed(frame_changed),
    .stall(stall), .scan_err(scan_err));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  // {err, value} of a glyph found by table search
  function automatic logic [4:0] classify(input logic [6:0] g);
    for (int i = 0; i < 16; i++) if (GLYPH[i] == g) return {1'b0, 4'(i)};
    return 5'b10000;
  endfunction

  function automatic logic [7:0] enc(input int v, input logic d);
    return {d, GLYPH[v]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 4'h0; m_dp[i] = 1'b0; m_err[i] = 1'b0; m_seen[i] = 1'b0;
    end
    m_first = 1'b1;
    m_last = '0;
    m_have_last = 1'b0;
    m_last_slot = 0;
  endtask

  task automatic model_capture(input int slot, input logic [7:0] s);
    logic [4:0] c;
    frame_t f;
    c = classify(s[6:0]);
    m_val[slot] = c[3:0];
    m_dp[slot]  = s[7];
    m_err[slot] = c[4];
    m_seen[slot] = 1'b1;
`ifdef SSEG_SCAN_ORDER_CHECK_EN
    if (m_have_last && slot != (m_last_slot + 1) % 4) exp_scan++;
`endif
    m_have_last = 1'b1;
    m_last_slot = slot;
    if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
      f.hex = {m_val[3], m_val[2], m_val[1], m_val[0]};
      f.dp  = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
      f.err = {m_err[3], m_err[2], m_err[1], m_err[0]};
      f.chg = 1'b0;
      f.chg = m_first || ({f.hex, f.dp, f.err} != {m_last.hex, m_last.dp, m_last.err});
      expq.push_back(f);
      frames_exp++;
      m_last = f;
      m_first = 1'b0;
      for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
    end
  endtask

  // Drive one dwell followed by a one-cycle blank so consecutive dwells never merge.
  task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int len);
    int slot;
    if ($countones(~a) == 1 && len >= SETTLE) begin
      slot = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) slot = i;
      model_capture(slot, s);
    end
    an = a; sseg = s;
    repeat (len) @(negedge clk);
    an = 4'hF; sseg = 8'hFF;
    @(negedge clk);
  endtask

  function automatic logic [3:0] sel(input int slot);
    logic [3:0] a;
    a = 4'hF;
    a[slot] = 1'b0;
    return a;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; an = 4'hF; sseg = 8'hFF;
    @(negedge clk);
    check("reset_outputs", {hex, dp, seg_err, frame_valid, frame_changed, stall, scan_err}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: pops the scoreboard whenever the DUT publishes a frame.
  always @(negedge clk) begin
    frame_t e;
    if (!reset && frame_valid) begin
      frames_obs++;
      if (expq.size() == 0) begin
        check("frame_unexpected", {hex, dp, seg_err}, 64'h0);
        if ({hex, dp, seg_err} == 24'h0) begin
          n_pass--;
          $display("FAIL frame_unexpected: got frame_valid with no expected frame");
        end
      end else begin
        e = expq.pop_front();
        check("frame", {hex, dp, seg_err, frame_changed}, e);
      end
    end
    if (!reset && scan_err) obs_scan++;
  end

  initial begin
    model_reset();
    do_reset();

    // digits 3..0 = 1,2,A,F with dp levels 1,0,1,1
    for (int rep = 0; rep < 2; rep++) begin
      dwell(sel(3), enc(1, 1'b1), 8);
      dwell(sel(2), enc(2, 1'b0), 8);
      dwell(sel(1), enc(10, 1'b1), 8);
      dwell(sel(0), enc(15, 1'b1), 8);
      repeat (3) @(negedge clk);
      check("plan_hex", hex, 64'h12AF);
      check("plan_dp", dp, 64'hB);
      check("plan_err", seg_err, 64'h0);
    end

    // short dwell on digit 1 is ignored until a full dwell arrives
    dwell(sel(3), enc(4, 1'b0), 8);
    dwell(sel(2), enc(5, 1'b1), 8);
    dwell(sel(1), enc(6, 1'b1), 3);
    dwell(sel(0), enc(7, 1'b0), 8);
    repeat (3) @(negedge clk);
    check("short_dwell_no_frame", frames_obs, 64'd2);
    dwell(sel(1), enc(6, 1'b1), 4);
    repeat (3) @(negedge clk);
    check("short_dwell_frame", frames_obs, 64'd3);

    // blank digit 2 decodes as error with nibble 0
    dwell(sel(3), enc(3, 1'b1), 8);
    dwell(sel(2), 8'hFF, 8);
    dwell(sel(1), enc(9, 1'b1), 8);
    dwell(sel(0), enc(8, 1'b1), 8);
    repeat (3) @(negedge clk);
    check("blank_nibble", hex[11:8], 64'h0);
    check("blank_err", seg_err, 64'h4);

    // stall: illegal anodes only, then one legal dwell
    do_reset();
    an = 4'b1100; sseg = enc(2, 1'b1);
    repeat (20) @(negedge clk);
    check("stall_early", stall, 64'd0);
    an = 4'b1111;
    repeat (25) @(negedge clk);
    check("stall_set", stall, 64'd1);
    model_capture(0, enc(5, 1'b1));
    an = sel(0); sseg = enc(5, 1'b1);
    repeat (4) @(negedge clk);
    check("stall_hold", stall, 64'd1);
    @(negedge clk);
    check("stall_drop", stall, 64'd0);
    repeat (3) @(negedge clk);
    an = 4'hF; sseg = 8'hFF;
    @(negedge clk);

    // reset mid-frame discards the partial frame
    dwell(sel(1), enc(1, 1'b0), 8);
    do_reset();
    dwell(sel(0), enc(12, 1'b1), 8);
    dwell(sel(1), enc(13, 1'b1), 8);
    dwell(sel(2), enc(14, 1'b1), 8);
    repeat (3) @(negedge clk);
    check("partial_no_frame", frames_obs, 64'd4);
    dwell(sel(3), enc(11, 1'b0), 8);

    // scan order 0,2,1,3 then 0,1,2,3
    dwell(sel(0), enc(1, 1'b1), 6);
    dwell(sel(2), enc(2, 1'b1), 6);
    dwell(sel(1), enc(3, 1'b1), 6);
    dwell(sel(3), enc(4, 1'b1), 6);
    for (int i = 0; i < 4; i++) dwell(sel(i), enc(i + 5, 1'b0), 6);

    // randomized dwells
    for (int n = 0; n < 400; n++) begin
      logic [3:0] a;
      logic [7:0] s;
      int slot;
      slot = (n % 4 == 0 || $urandom_range(9) > 1) ? (n % 4) : $urandom_range(3);
      a = sel(slot);
      if ($urandom_range(19) == 0) a = 4'($urandom_range(15));
      s = enc($urandom_range(15), 1'($urandom_range(1)));
      if ($urandom_range(9) == 0) s = 8'($urandom_range(255));
      dwell(a, s, $urandom_range(8, 1));
    end

    repeat (10) @(negedge clk);
    check("queue_drained", expq.size(), 64'd0);
    check("frame_count", frames_obs, frames_exp);
    check("scan_err_count", obs_scan, exp_scan);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
